// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
//   loader_state_t : frame-parser states
//   WORD_BYTES     : bytes per instruction word
//   checksum_add   : mod-256 running checksum step
package loader_pkg;

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, FAIL} loader_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BIDX_W     = $clog2(WORD_BYTES);

  function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler.
//   clk, reset   : clock, async active-high reset
//   clear        : synchronous restart (byte counter back to 0)
//   push, data   : accepted stream byte
//   word         : assembled word, valid together with word_valid
//   word_valid   : combinational pulse in the cycle the last byte of a word is pushed
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BIDX_W-1:0] byte_idx;
  logic [23:0]       low;

  // Bytes enter at the top and shift down, so after three pushes the oldest
  // byte sits at bits [7:0]; the fourth byte completes the word directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      low      <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (push) begin
      low      <= {data, low[23:8]};
      byte_idx <= byte_idx + 1'b1;
    end
  end

  assign word_valid = push && (byte_idx == BIDX_W'(WORD_BYTES - 1));
  assign word       = {data, low};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses LEN_LO, LEN_HI, 4*N data bytes, CSUM from a byte
// stream, writes packed words into instruction memory and releases the core
// from reset once the checksum matches.
//   clk, reset              : clock, async active-high reset
//   rx_valid/rx_data/rx_ready : byte stream handshake
//   reload                  : restart pulse, honoured in RUN/FAIL only
//   imem_we/addr/wdata      : instruction memory write port (registered)
//   core_reset              : held high until a verified load
//   done / error            : RUN / FAIL status
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  loader_state_t    state, state_nx;
  logic             accept, restart;
  logic [CNT_W-1:0] n_len, n_full, word_idx;
  logic [7:0]       sum;
  logic [31:0]      word;
  logic             word_valid;

  assign n_full  = CNT_W'({rx_data, n_len[7:0]});
  assign restart = reload && (state == RUN || state == FAIL);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .push       (accept && state == DATA),
    .data       (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LEN0;
    else       state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      LEN0: if (accept) state_nx = LEN1;
      LEN1: if (accept) begin
        if (n_full > CNT_W'(DEPTH_WORDS)) state_nx = FAIL;
        else if (n_full == '0)            state_nx = CSUM;
        else                              state_nx = DATA;
      end
      DATA: if (word_valid && word_idx == n_len - 1'b1) state_nx = CSUM;
      CSUM: if (accept) state_nx = (rx_data == sum) ? RUN : FAIL;
      RUN, FAIL: if (reload) state_nx = LEN0;
      default: state_nx = LEN0;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    rx_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    accept   = rx_valid && rx_ready;
  end

  // Status flags follow the next state so core_reset drops on the very edge
  // that enters RUN and rises again on the edge that leaves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      n_len      <= '0;
      word_idx   <= '0;
      sum        <= '0;
    end else begin
      core_reset <= (state_nx != RUN);
      done       <= (state_nx == RUN);
      error      <= (state_nx == FAIL);
      imem_we    <= word_valid;
      if (word_valid) begin
        imem_addr  <= 32'(word_idx) << 2;
        imem_wdata <= word;
      end
      if (accept && state == LEN0) n_len <= CNT_W'(rx_data);
      if (accept && state == LEN1) n_len <= n_full;
      if (restart)         word_idx <= '0;
      else if (word_valid) word_idx <= word_idx + 1'b1;
      // CSUM byte itself is compared, not accumulated
      if (restart)                        sum <= '0;
      else if (accept && state != CSUM)   sum <= checksum_add(sum, rx_data);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid, rx_ready, reload;
  logic [7:0]  rx_data;
  logic        imem_we, core_reset, done, error;
  logic [31:0] imem_addr, imem_wdata;

  imem_boot_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  logic [31:0] wr_a[$], wr_d[$];
  int          wr_c[$], hs[$];
  bit          ready_ok;

  always @(posedge clk) cyc <= cyc + 1;

  // write-port monitor: one record per cycle with imem_we high
  always @(negedge clk) begin
    if (imem_we) begin
      wr_a.push_back(imem_addr);
      wr_d.push_back(imem_wdata);
      wr_c.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: derive writes and final status straight from the frame bytes.
  task automatic model(input logic [7:0] fr[$], output logic [31:0] ea[$],
                       output logic [31:0] ed[$], output bit edone, output bit eerr);
    int n;
    logic [7:0] s;
    ea.delete(); ed.delete();
    n = int'(fr[0]) + 256 * int'(fr[1]);
    if (n > DEPTH) begin
      edone = 0; eerr = 1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      ea.push_back(32'(4 * w));
      ed.push_back({fr[2+4*w+3], fr[2+4*w+2], fr[2+4*w+1], fr[2+4*w]});
    end
    s = 8'h00;
    for (int i = 0; i < fr.size() - 1; i++) s = s + fr[i];
    edone = (fr[fr.size()-1] == s);
    eerr  = !edone;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit rl_en);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk); rx_valid = 1'b0; reload = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    reload = rl_en && ($urandom_range(0, 3) == 0);
    if (!rx_ready) ready_ok = 0;
    @(posedge clk); #1;
    hs.push_back(cyc);
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input int max_gap, input bit rl_en, input string tag);
    logic [31:0] ea[$], ed[$];
    bit edone, eerr;
    model(fr, ea, ed, edone, eerr);
    wr_a.delete(); wr_d.delete(); wr_c.delete(); hs.delete();
    ready_ok = 1;
    foreach (fr[i]) send_byte(fr[i], $urandom_range(0, max_gap), rl_en);
    // status on the edge that accepted the final byte
    chk({tag, ".done"},       done,       edone);
    chk({tag, ".error"},      error,      eerr);
    chk({tag, ".core_reset"}, core_reset, !edone);
    chk({tag, ".rx_ready"},   rx_ready,   1'b0);
    @(negedge clk); rx_valid = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, ".ready_in_frame"}, ready_ok, 1);
    chk({tag, ".nwrites"}, wr_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), wr_a[i], ea[i]);
      chk($sformatf("%s.data%0d", tag, i), wr_d[i], ed[i]);
      if (hs.size() > 4*i + 5)
        chk($sformatf("%s.lat%0d", tag, i), wr_c[i], hs[4*i+5]);
    end
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    chk({tag, ".rl_ready"}, rx_ready,   1'b1);
    chk({tag, ".rl_error"}, error,      1'b0);
    chk({tag, ".rl_done"},  done,       1'b0);
    chk({tag, ".rl_creset"}, core_reset, 1'b1);
  endtask

  typedef struct {
    int          len;
    logic [7:0]  b[12];
    bit          exp_done;
    bit          exp_err;
    int          exp_nw;
    logic [31:0] w[2];
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [7:0] fr[$];
    // 0x02+0x13+0x50+0x93+0xA0 = 0x198 -> checksum 0x98
    vt[0].len = 11; vt[0].b = '{8'h02,8'h00,8'h13,8'h00,8'h50,8'h00,8'h93,8'h00,8'hA0,8'h00,8'h98,8'h00};
    vt[0].exp_done = 1; vt[0].exp_err = 0; vt[0].exp_nw = 2; vt[0].w = '{32'h00500013, 32'h00A00093};
    vt[1].len = 11; vt[1].b = '{8'h02,8'h00,8'h13,8'h00,8'h50,8'h00,8'h93,8'h00,8'hA0,8'h00,8'h33,8'h00};
    vt[1].exp_done = 0; vt[1].exp_err = 1; vt[1].exp_nw = 2; vt[1].w = '{32'h00500013, 32'h00A00093};
    vt[2].len = 3;  vt[2].b = '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    vt[2].exp_done = 1; vt[2].exp_err = 0; vt[2].exp_nw = 0; vt[2].w = '{32'h0, 32'h0};
    vt[3].len = 2;  vt[3].b = '{8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    vt[3].exp_done = 0; vt[3].exp_err = 1; vt[3].exp_nw = 0; vt[3].w = '{32'h0, 32'h0};
    // 0x01 + 4*0xFF = 0x3FD -> checksum wraps to 0xFD
    vt[4].len = 7;  vt[4].b = '{8'h01,8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'hFD,8'h00,8'h00,8'h00,8'h00,8'h00};
    vt[4].exp_done = 1; vt[4].exp_err = 0; vt[4].exp_nw = 1; vt[4].w = '{32'hFFFFFFFF, 32'h0};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.rx_ready",   rx_ready,   1'b1);
    chk("rst.core_reset", core_reset, 1'b1);
    chk("rst.done",       done,       1'b0);
    chk("rst.error",      error,      1'b0);
    chk("rst.imem_we",    imem_we,    1'b0);
    chk("rst.imem_addr",  imem_addr,  32'h0);
    chk("rst.imem_wdata", imem_wdata, 32'h0);
    reset = 1'b0;

    // table vectors
    for (int v = 0; v < 5; v++) begin
      fr.delete();
      for (int i = 0; i < vt[v].len; i++) fr.push_back(vt[v].b[i]);
      run_frame(fr, 0, 0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d.tbl_nw", v),   wr_a.size(), vt[v].exp_nw);
      chk($sformatf("vec%0d.tbl_done", v), done,        vt[v].exp_done);
      chk($sformatf("vec%0d.tbl_err", v),  error,       vt[v].exp_err);
      for (int i = 0; i < vt[v].exp_nw && i < wr_d.size(); i++)
        chk($sformatf("vec%0d.tbl_w%0d", v, i), wr_d[i], vt[v].w[i]);
      do_reload($sformatf("vec%0d", v));
    end

    // random 3-word frames with gaps and ignored reload pulses
    for (int it = 0; it < 6; it++) begin
      logic [7:0] s;
      fr.delete();
      fr.push_back(8'd3); fr.push_back(8'd0);
      for (int i = 0; i < 12; i++) fr.push_back(8'($urandom));
      s = 8'h00;
      foreach (fr[i]) s = s + fr[i];
      if ($urandom_range(0, 2) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
      fr.push_back(s);
      run_frame(fr, 7, 1, $sformatf("rnd%0d", it));
      do_reload($sformatf("rnd%0d", it));
    end

    // full-depth image: last address is (DEPTH-1)*4
    begin
      logic [7:0] s;
      fr.delete();
      fr.push_back(8'(DEPTH & 8'hFF)); fr.push_back(8'(DEPTH >> 8));
      for (int i = 0; i < 4*DEPTH; i++) fr.push_back(8'($urandom));
      s = 8'h00;
      foreach (fr[i]) s = s + fr[i];
      fr.push_back(s);
      run_frame(fr, 1, 0, "full");
      if (wr_a.size() > 0) chk("full.last_addr", wr_a[wr_a.size()-1], 32'((DEPTH-1)*4));
      else                 chk("full.last_addr", 32'hFFFFFFFF, 32'((DEPTH-1)*4));
      do_reload("full");
    end

    // reset after five data bytes aborts asynchronously
    begin
      logic [7:0] part[7];
      part = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      foreach (part[i]) send_byte(part[i], 0, 0);
      #2; reset = 1'b1; rx_valid = 1'b0;
      #1;
      chk("arst.rx_ready",   rx_ready,   1'b1);
      chk("arst.core_reset", core_reset, 1'b1);
      chk("arst.done",       done,       1'b0);
      chk("arst.error",      error,      1'b0);
      chk("arst.imem_we",    imem_we,    1'b0);
      chk("arst.imem_addr",  imem_addr,  32'h0);
      chk("arst.imem_wdata", imem_wdata, 32'h0);
      @(negedge clk); reset = 1'b0;
      fr.delete();
      fr = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
      begin
        logic [7:0] s;
        s = 8'h00;
        foreach (fr[i]) s = s + fr[i];
        fr.push_back(s);
      end
      run_frame(fr, 3, 0, "post_rst");
      if (wr_d.size() > 0) chk("post_rst.w0", wr_d[0], 32'hDEADBEEF);
      else                 chk("post_rst.w0", 32'h0, 32'hDEADBEEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
